// File: rtl/rr_switch_allocator_if.sv
// Request/grant bundle between the input buffers, the allocator and the crossbar.
// slave is the allocator side; master is the buffer/downstream side that drives requests.
interface rr_switch_allocator_if #(
   parameter int unsigned IN_N      = 5,
   parameter int unsigned OUT_M     = 5,
   parameter int unsigned FLIT_ID_W = 2
);
   localparam int unsigned SelW = (IN_N > 1) ? $clog2(IN_N) : 1;
   localparam int unsigned DstW = (OUT_M > 1) ? $clog2(OUT_M) : 1;

   logic [IN_N-1:0]           req_valid_i;
   logic [IN_N*DstW-1:0]      req_dst_i;
   logic [IN_N*FLIT_ID_W-1:0] flit_id_i;
   logic [OUT_M-1:0]          out_ready_i;
   logic [IN_N-1:0]           grant_o;
   logic [OUT_M*SelW-1:0]     sel_o;
   logic [OUT_M-1:0]          out_valid_o;

   modport slave (
      input  req_valid_i,
      input  req_dst_i,
      input  flit_id_i,
      input  out_ready_i,
      output grant_o,
      output sel_o,
      output out_valid_o
   );

   modport master (
      output req_valid_i,
      output req_dst_i,
      output flit_id_i,
      output out_ready_i,
      input  grant_o,
      input  sel_o,
      input  out_valid_o
   );
endinterface

// File: rtl/rr_switch_allocator.sv
// Per-output wormhole switch allocator. Round-robin among head flits on an idle output,
// then the output stays locked to the winner until its tail flit transfers. Outputs are
// combinational from the request inputs and the registered per-output state.
// OUT_M must equal IN_N so the select bus matches the downstream crossbar.
module rr_switch_allocator #(
   parameter int unsigned IN_N      = 5,
   parameter int unsigned OUT_M     = 5,
   parameter int unsigned FLIT_ID_W = 2
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   rr_switch_allocator_if.slave bus
);
   localparam int unsigned SelW = (IN_N > 1) ? $clog2(IN_N) : 1;
   localparam int unsigned DstW = (OUT_M > 1) ? $clog2(OUT_M) : 1;

   typedef enum logic [0:0] {StIdle, StLocked} state_e;

   state_e          state_q [OUT_M];
   state_e          state_d [OUT_M];
   logic [SelW-1:0] owner_q [OUT_M];
   logic [SelW-1:0] owner_d [OUT_M];
   logic [SelW-1:0] rr_q    [OUT_M];
   logic [SelW-1:0] rr_d    [OUT_M];

   logic [DstW-1:0] dst   [IN_N];
   logic [IN_N-1:0] head;
   logic [IN_N-1:0] tail;

   logic [IN_N-1:0]       grant;
   logic [OUT_M-1:0]      out_valid;
   logic [OUT_M*SelW-1:0] sel;

   // Unpack the per-input destination and flit-ID fields.
   always_comb begin
      head = '0;
      tail = '0;
      for (int n = 0; n < IN_N; n++) begin
         dst[n]  = bus.req_dst_i[n*DstW +: DstW];
         head[n] = bus.flit_id_i[n*FLIT_ID_W + 1];
         tail[n] = bus.flit_id_i[n*FLIT_ID_W];
      end
   end

   // Per-output arbitration, lock tracking and next-state computation.
   always_comb begin
      logic [IN_N-1:0] cand;
      logic            found;
      logic [SelW-1:0] win;
      logic [SelW:0]   sum;
      logic [SelW-1:0] idx;
      logic [SelW-1:0] sel_m;

      grant     = '0;
      out_valid = '0;
      sel       = '0;
      cand      = '0;
      found     = 1'b0;
      win       = '0;
      sum       = '0;
      idx       = '0;
      sel_m     = '0;

      for (int m = 0; m < OUT_M; m++) begin
         state_d[m] = state_q[m];
         owner_d[m] = owner_q[m];
         rr_d[m]    = rr_q[m];
         sel_m      = owner_q[m];
         found      = 1'b0;
         win        = '0;

         for (int n = 0; n < IN_N; n++) begin
            cand[n] = bus.req_valid_i[n] & head[n] & (dst[n] == DstW'(m));
         end

         unique case (state_q[m])
            StIdle: begin
               // Scan rr_ptr, rr_ptr+1, ... modulo IN_N; first candidate wins.
               for (int k = 0; k < IN_N; k++) begin
                  sum = {1'b0, rr_q[m]} + (SelW+1)'(k);
                  if (sum >= (SelW+1)'(IN_N)) begin
                     sum = sum - (SelW+1)'(IN_N);
                  end
                  idx = sum[SelW-1:0];
                  if (!found && cand[idx]) begin
                     found = 1'b1;
                     win   = idx;
                  end
               end
               if (bus.out_ready_i[m] && found) begin
                  grant[win]   = 1'b1;
                  out_valid[m] = 1'b1;
                  sel_m        = win;
                  owner_d[m]   = win;
                  rr_d[m]      = (win == SelW'(IN_N - 1)) ? '0 : win + 1'b1;
                  // A single-flit packet releases the output immediately.
                  state_d[m]   = tail[win] ? StIdle : StLocked;
               end
            end
            StLocked: begin
               if (bus.req_valid_i[owner_q[m]] && bus.out_ready_i[m]) begin
                  grant[owner_q[m]] = 1'b1;
                  out_valid[m]      = 1'b1;
                  if (tail[owner_q[m]]) begin
                     state_d[m] = StIdle;
                  end
               end
            end
            default: begin
               state_d[m] = StIdle;
            end
         endcase

         sel[m*SelW +: SelW] = sel_m;
      end
   end

   // Outputs are forced low while reset is held, independent of the request inputs.
   always_comb begin
      bus.grant_o     = rst_ni ? grant : '0;
      bus.out_valid_o = rst_ni ? out_valid : '0;
      bus.sel_o       = rst_ni ? sel : '0;
   end

   // Per-output state registers; a reset drops any lock in progress.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int m = 0; m < OUT_M; m++) begin
            state_q[m] <= StIdle;
            owner_q[m] <= '0;
            rr_q[m]    <= '0;
         end
      end else begin
         for (int m = 0; m < OUT_M; m++) begin
            state_q[m] <= state_d[m];
            owner_q[m] <= owner_d[m];
            rr_q[m]    <= rr_d[m];
         end
      end
   end
endmodule

// File: tb/tb_rr_switch_allocator.sv
// Directed testbench for rr_switch_allocator with hand-computed expected grants.
module tb_rr_switch_allocator;
   localparam int unsigned IN_N  = 5;
   localparam int unsigned OUT_M = 5;
   localparam int unsigned FW    = 2;
   localparam int unsigned SW    = 3;
   localparam int unsigned DW    = 3;

   localparam logic [1:0] Head   = 2'b10;
   localparam logic [1:0] Body   = 2'b00;
   localparam logic [1:0] Tail   = 2'b01;
   localparam logic [1:0] Single = 2'b11;

   logic clk_i = 1'b0;
   logic rst_ni;

   always #5 clk_i = ~clk_i;

   rr_switch_allocator_if #(.IN_N(IN_N), .OUT_M(OUT_M), .FLIT_ID_W(FW)) bus ();

   rr_switch_allocator #(
      .IN_N      (IN_N),
      .OUT_M     (OUT_M),
      .FLIT_ID_W (FW)
   ) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic drive(input int n, input int d, input logic [1:0] id);
      bus.req_valid_i[n]         = 1'b1;
      bus.req_dst_i[n*DW +: DW]  = DW'(d);
      bus.flit_id_i[n*FW +: FW]  = id;
   endtask

   task automatic drop(input int n);
      bus.req_valid_i[n] = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [2:0] sel_of(input int m);
      return bus.sel_o[m*SW +: SW];
   endfunction

   // Wait for the sampling edge and compare grant and out_valid.
   task automatic expect_cycle(input string tag, input logic [4:0] g, input logic [4:0] ov);
      @(negedge clk_i);
      check({tag, " grant"}, 32'(bus.grant_o), 32'(g));
      check({tag, " out_valid"}, 32'(bus.out_valid_o), 32'(ov));
   endtask

   initial begin
      rst_ni          = 1'b0;
      bus.req_valid_i = '0;
      bus.req_dst_i   = '0;
      bus.flit_id_i   = '0;
      bus.out_ready_i = '1;

      // Reset forces outputs low even with a live request.
      drive(0, 0, Single);
      #2;
      check("rst grant", 32'(bus.grant_o), 32'd0);
      check("rst out_valid", 32'(bus.out_valid_o), 32'd0);
      check("rst sel", 32'(bus.sel_o), 32'd0);
      drop(0);
      tick();
      rst_ni = 1'b1;
      tick();

      // 3-flit packet, input 2 -> output 4.
      drive(2, 4, Head);
      expect_cycle("t1 head", 5'b00100, 5'b10000);
      check("t1 sel4 head", 32'(sel_of(4)), 32'd2);
      tick();
      drive(2, 4, Body);
      expect_cycle("t1 body", 5'b00100, 5'b10000);
      tick();
      drive(2, 4, Tail);
      expect_cycle("t1 tail", 5'b00100, 5'b10000);
      check("t1 sel4 tail", 32'(sel_of(4)), 32'd2);
      tick();
      // rr_ptr of output 4 is now 3: input 3 beats input 2.
      drive(2, 4, Single);
      drive(3, 4, Single);
      expect_cycle("t1 rr3", 5'b01000, 5'b10000);
      check("t1 sel4 rr", 32'(sel_of(4)), 32'd3);
      tick();
      drop(3);
      expect_cycle("t1 rr4", 5'b00100, 5'b10000);
      tick();
      drop(2);

      // Round-robin on output 0 among inputs 0, 1, 3.
      drive(0, 0, Single);
      drive(1, 0, Single);
      drive(3, 0, Single);
      expect_cycle("t2 c1", 5'b00001, 5'b00001);
      tick();
      drop(0);
      expect_cycle("t2 c2", 5'b00010, 5'b00001);
      tick();
      drop(1);
      expect_cycle("t2 c3", 5'b01000, 5'b00001);
      tick();
      drop(3);
      drive(0, 0, Single);
      drive(1, 0, Single);
      expect_cycle("t2 wrap", 5'b00001, 5'b00001);
      tick();
      drop(0);
      expect_cycle("t2 c5", 5'b00010, 5'b00001);
      tick();
      drop(1);

      // Input 1 locked on output 2; input 4 head waits for the tail.
      drive(1, 2, Head);
      expect_cycle("t3 head", 5'b00010, 5'b00100);
      tick();
      drive(1, 2, Body);
      drive(4, 2, Single);
      expect_cycle("t3 body1", 5'b00010, 5'b00100);
      check("t3 sel2 lock", 32'(sel_of(2)), 32'd1);
      tick();
      expect_cycle("t3 body2", 5'b00010, 5'b00100);
      tick();
      drive(1, 2, Tail);
      expect_cycle("t3 tail", 5'b00010, 5'b00100);
      tick();
      drop(1);
      expect_cycle("t3 next", 5'b10000, 5'b00100);
      check("t3 sel2 next", 32'(sel_of(2)), 32'd4);
      tick();
      drop(4);

      // 4-flit packet input 0 -> output 3 with 2 stalled cycles.
      drive(0, 3, Head);
      expect_cycle("t4 head", 5'b00001, 5'b01000);
      tick();
      drive(0, 3, Body);
      bus.out_ready_i = 5'b10111;
      expect_cycle("t4 stall1", 5'b00000, 5'b00000);
      check("t4 sel3 stall", 32'(sel_of(3)), 32'd0);
      tick();
      expect_cycle("t4 stall2", 5'b00000, 5'b00000);
      tick();
      bus.out_ready_i = '1;
      expect_cycle("t4 body1", 5'b00001, 5'b01000);
      tick();
      expect_cycle("t4 body2", 5'b00001, 5'b01000);
      tick();
      drive(0, 3, Tail);
      expect_cycle("t4 tail", 5'b00001, 5'b01000);
      tick();
      drive(0, 3, Body);
      expect_cycle("t4 unlocked", 5'b00000, 5'b00000);
      tick();
      drop(0);

      // Parallel traffic n -> (n+1) mod 5.
      for (int n = 0; n < 5; n++) drive(n, (n + 1) % 5, Single);
      expect_cycle("t5 par", 5'b11111, 5'b11111);
      check("t5 sel", 32'(bus.sel_o), 32'({3'd3, 3'd2, 3'd1, 3'd0, 3'd4}));
      tick();
      for (int n = 0; n < 5; n++) drop(n);

      // Reset pulse in the middle of a locked packet.
      drive(3, 1, Head);
      expect_cycle("t6 head", 5'b01000, 5'b00010);
      tick();
      drive(3, 1, Body);
      expect_cycle("t6 body", 5'b01000, 5'b00010);
      #1;
      rst_ni = 1'b0;
      #1;
      check("t6 rst grant", 32'(bus.grant_o), 32'd0);
      check("t6 rst out_valid", 32'(bus.out_valid_o), 32'd0);
      check("t6 rst sel", 32'(bus.sel_o), 32'd0);
      #1;
      rst_ni = 1'b1;
      tick();
      expect_cycle("t6 stray1", 5'b00000, 5'b00000);
      tick();
      expect_cycle("t6 stray2", 5'b00000, 5'b00000);
      tick();
      drive(3, 1, Single);
      expect_cycle("t6 new", 5'b01000, 5'b00010);
      check("t6 sel1", 32'(sel_of(1)), 32'd3);
      tick();
      drop(3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/rr_switch_allocator.md
# rr_switch_allocator

Per-output wormhole switch allocator for the router. It sits directly upstream of the N×N parallel crossbar and drives that crossbar's packed select bus. Each cycle it grants at most one input to each output port. Arbitration is round-robin on head flits, and the output stays locked to the winning input until that input's tail flit has passed. It also tells the input buffers which flits move this cycle.

## Interface
- IN_N, default 5: number of input channels.
- OUT_M, default 5: number of output channels. Must equal IN_N, because the crossbar's select width requires it.
- FLIT_ID_W, default 2: width of the flit ID field. Bit 1 is head, bit 0 is tail.
  - 2'b10 = head
  - 2'b00 = body
  - 2'b01 = tail
  - 2'b11 = single-flit packet

Ports (one clock; reset is asynchronous and active-low):
- clk_i, input, 1: router clock.
- rst_ni, input, 1: asynchronous active-low reset.
- req_valid_i, input, IN_N: input n has a flit at the head of its buffer.
- req_dst_i, input, IN_N*$clog2(OUT_M): destination output port per input, packed with input 0 at the LSBs. Only sampled for head flits.
- flit_id_i, input, IN_N*FLIT_ID_W: flit ID of each input's head-of-buffer flit, packed.
- out_ready_i, input, OUT_M: downstream of output m can accept a flit this cycle.
- grant_o, output, IN_N: the flit of input n transfers this cycle, and the buffer pops it.
- sel_o, output, OUT_M*$clog2(IN_N): crossbar select per output, packed with output 0 at the LSBs.
- out_valid_o, output, OUT_M: output m carries a valid flit this cycle.

## Operation
- Per-output state:
  - FSM with states IDLE and LOCKED.
  - owner register, $clog2(IN_N) bits.
  - rr_ptr register, $clog2(IN_N) bits.
- IDLE:
  - Candidates are inputs n where req_valid_i[n] is set, the head bit is set, and req_dst_i[n] equals m.
  - If out_ready_i[m] is set and there is at least one candidate, the winner is the first candidate found searching rr_ptr, rr_ptr+1, … modulo IN_N.
  - On a win: assert grant_o[winner] and out_valid_o[m]; sel_o[m] = winner; owner ← winner; rr_ptr ← winner+1 (wraps from IN_N-1 to 0).
  - Next state is LOCKED if the flit is not a tail (ID 2'b10), and stays IDLE for a single-flit packet (ID 2'b11).
- LOCKED:
  - sel_o[m] = owner.
  - If req_valid_i[owner] and out_ready_i[m] are both set: assert grant_o[owner] and out_valid_o[m].
  - req_dst_i is ignored in LOCKED.
  - When the granted flit's tail bit is set, next state is IDLE. rr_ptr is unchanged in LOCKED.
- Outputs with no grant: out_valid_o[m] = 0 and sel_o[m] = owner (held).
- An output that is not ready grants nothing, and neither the state nor rr_ptr changes.
- Head flit aimed at a LOCKED output: it waits. It is not granted and not queued.
- Body or tail flit with no owning output: never granted. This is a protocol error; the block raises no flag and does not hang.
- Because each input has one destination at a time and body flits are only served by their owner, grant_o comes from at most one output. The grant is the OR across outputs.
- A head flit with the tail bit set while in LOCKED (owner sends 2'b11) is treated as a tail: it is granted and the output goes back to IDLE.

## Timing
- grant_o, sel_o and out_valid_o are combinational from the inputs and the registered state. Latency is 0 cycles from request to grant.
- State, owner and rr_ptr update on the rising edge of clk_i, and only on a grant.
- Asynchronous reset (rst_ni = 0), effective immediately:
  - Every output goes to IDLE, with owner = 0 and rr_ptr = 0.
  - grant_o = 0, out_valid_o = 0 and sel_o = 0, forced for as long as rst_ni is low.
  - A reset in the middle of a packet drops the lock. After reset, the remaining body flits of that packet are never granted.
- Throughput: one flit per output per cycle, so up to OUT_M flits per cycle.
- A packet of length L with no stalls holds its output for exactly L consecutive cycles.
- The first head grant to a freshly IDLE output can happen in the same cycle as the previous tail grant's state update. The IDLE→grant path in the cycle after a tail has no bubble.

## Test plan
- Reset, then input 2 sends a 3-flit packet (IDs 10, 00, 01) to output 4 with out_ready all ones:
  - grant_o = 5'b00100 for 3 consecutive cycles.
  - sel_o[4] = 2, out_valid_o[4] = 1.
  - Output 4 is IDLE afterwards with rr_ptr = 3.
- Inputs 0, 1 and 3 all hold single-flit (11) heads to output 0, starting from rr_ptr = 0:
  - Grants go to 0, then 1, then 3 on successive cycles.
  - A fresh head from input 0 on the fourth cycle wins after 3 (wrap-around).
- Input 1 is locked to output 2 mid-packet when input 4 presents a head to output 2:
  - Input 4 gets no grant until the cycle after input 1's tail is granted.
- out_ready_i[3] is dropped for 2 cycles during a 4-flit packet from input 0:
  - grant_o[0] = 0 and out_valid_o[3] = 0 in those cycles.
  - The lock is kept and the packet completes after 6 cycles.
- Parallel traffic, inputs 0→1, 1→2, 2→3, 3→4 and 4→0, all heads in the same cycle:
  - grant_o = 5'b11111.
  - sel_o = {3, 2, 1, 0, 4} for outputs 4 down to 0.
- rst_ni is pulsed low during a locked packet:
  - Outputs are 0 immediately.
  - After release, the stray body flit is never granted and a new head to the same output is granted.
